// File: rtl/register_file.sv
// register_file: 2^a_width x d_width register file, entry 0 hardwired to zero, two combinational reads, one synchronous write.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a read port addressing waddr.
module register_file #(
    parameter int d_width = 32,
    parameter int a_width = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wen,
    input  logic [a_width-1:0] waddr,
    input  logic [d_width-1:0] wdata,
    input  logic [a_width-1:0] raddr1,
    input  logic [a_width-1:0] raddr2,
    output logic [d_width-1:0] rdata1,
    output logic [d_width-1:0] rdata2
);
    localparam int depth = 1 << a_width;

    // rst_n is active-high despite its name; it clears storage asynchronously
    logic               wr_ok;
    logic [d_width-1:0] view [depth];

    assign wr_ok   = wen && (waddr != '0);
    assign view[0] = '0;

    for (genvar i = 1; i < depth; i++) begin : g_reg
        logic [d_width-1:0] data_q;
        logic [d_width-1:0] data_d;
        assign data_d  = (wr_ok && waddr == a_width'(i)) ? wdata : data_q;
        assign view[i] = data_q;
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) data_q <= '0;
            else       data_q <= data_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1, fwd2;
    assign fwd1   = wr_ok && !rst_n && (raddr1 == waddr);
    assign fwd2   = wr_ok && !rst_n && (raddr2 == waddr);
    assign rdata1 = (raddr1 == '0) ? '0 : fwd1 ? wdata : view[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : fwd2 ? wdata : view[raddr2];
`else
    assign rdata1 = (raddr1 == '0) ? '0 : view[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : view[raddr2];
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed test-plan steps followed by random traffic against an array reference model.
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata1, rdata2;
    logic [31:0] model [32];
    int          total = 0;
    int          bad = 0;

    register_file #(.d_width(32), .a_width(5)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wen && !rst_n && waddr == a) return wdata;
`endif
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n && wen && waddr != 5'd0) model[waddr] = wdata;
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        raddr1 = a1;
        raddr2 = a2;
        #1;
        check({tag, "_p1"}, rdata1, ref_rd(a1));
        check({tag, "_p2"}, rdata2, ref_rd(a2));
    endtask

    initial begin
        clear_model();
        #1;
        check("reset_async_p1", rdata1, 32'd0);
        tick();
        rst_n = 1'b0;
        rd("rst_0_1", 5'd0, 5'd1);
        rd("rst_2_20", 5'd2, 5'd20);
        rd("rst_31_31", 5'd31, 5'd31);
        check("rst_31_const", rdata1, 32'd0);

        wen = 1'b1; waddr = 5'd1;  wdata = 32'd10; tick();
        waddr = 5'd2;  wdata = 32'd20; tick();
        waddr = 5'd20; wdata = 32'd40; tick();
        wen = 1'b0;
        rd("dual_1_2", 5'd1, 5'd2);
        check("dual_1_const", rdata1, 32'd10);
        check("dual_2_const", rdata2, 32'd20);
        rd("dual_20_2", 5'd20, 5'd2);
        check("dual_20_const", rdata1, 32'd40);

        wen = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; tick();
        wen = 1'b0;
        rd("x0", 5'd0, 5'd0);
        check("x0_const", rdata1, 32'd0);

        waddr = 5'd1; wdata = 32'd99;
        repeat (3) tick();
        rd("wen_gate", 5'd1, 5'd20);
        check("wen_gate_const", rdata1, 32'd10);

        #2;
        rst_n = 1'b1;
        clear_model();
        #1;
        check("midrst_p1", rdata1, 32'd0);
        check("midrst_p2", rdata2, 32'd0);
        wen = 1'b1; waddr = 5'd3; wdata = 32'd5;
        tick();
        tick();
        rst_n = 1'b0; wen = 1'b0;
        rd("rst_write_lost", 5'd3, 5'd3);
        check("rst_write_lost_const", rdata1, 32'd0);

        raddr1 = 5'd7; wen = 1'b1; waddr = 5'd7; wdata = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_before", rdata1, 32'h55);
`else
        check("same_cycle_before", rdata1, 32'd0);
`endif
        tick();
        wen = 1'b0;
        #1;
        check("same_cycle_after", rdata1, 32'h55);

        for (int n = 0; n < 400; n++) begin
            rst_n  = ($urandom_range(0, 39) == 0);
            wen    = $urandom_range(0, 1);
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            if (rst_n) clear_model();
            #1;
            check("rand_p1", rdata1, ref_rd(raddr1));
            check("rand_p2", rdata2, ref_rd(raddr2));
            tick();
        end
        rst_n = 1'b0; wen = 1'b0;
        for (int a = 0; a < 32; a++) rd("sweep", 5'(a), 5'(31 - a));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
